// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types for the frame-atomic FIFO write arbiter.
package fifo_arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DROP = 2'd2
    } arb_state_t;

    localparam int FRAME_CNT_W = 16;
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester beat handshake plus the async-FIFO write port, as seen by the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8
);
    logic [N_REQ-1:0]                 req_valid;
    logic [N_REQ-1:0][DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]                 req_last;
    logic [N_REQ-1:0]                 req_ready;
    logic                             w_en;
    logic [DATA_WIDTH:0]              w_data;
    logic                             w_full;

    modport master (
        input  req_valid, req_data, req_last, w_full,
        output req_ready, w_en, w_data
    );

    modport slave (
        output req_valid, req_data, req_last, w_full,
        input  req_ready, w_en, w_data
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [$clog2(N_REQ)-1:0] o_grant,
    output logic                     o_any
);
    localparam int IW = $clog2(N_REQ);

    int w_idx;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        o_grant = '0;
        w_idx   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % N_REQ;
            if (i_req[w_idx]) o_grant = w_idx[IW-1:0];
        end
    end

    assign o_any = |i_req;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Frame-atomic round-robin arbiter sharing one async-FIFO write port; oversize
// frames are cut at MAX_BEATS (forced last) and their tail is drained.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BEATS  = 1518
) (
    input  logic                     wclk,
    input  logic                     wrst_n,
    fifo_wr_arbiter_if.master        bus,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic                     err_oversize,
    output logic [FRAME_CNT_W-1:0]   frame_cnt
);
    localparam int IW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);

    arb_state_t             r_state, w_state_nxt;
    logic [IW-1:0]          r_owner, w_owner_nxt;
    logic [IW-1:0]          r_rr_ptr, w_rr_ptr_nxt;
    logic [BW-1:0]          r_beat_cnt, w_beat_cnt_nxt;
    logic [FRAME_CNT_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
    logic                   r_err, w_err_nxt;
    logic [IW-1:0]          w_grant, w_owner_inc;
    logic                   w_any, w_last_out;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    assign w_owner_inc = (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + IW'(1);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_beat_cnt  <= '0;
            r_frame_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_frame_cnt_nxt = r_frame_cnt;
        w_err_nxt       = 1'b0;
        w_last_out      = 1'b0;
        bus.req_ready   = '0;
        bus.w_en        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_owner_nxt    = w_grant;
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = XFER;
                end
            end
            XFER: begin
                bus.req_ready[r_owner] = !bus.w_full;
                if (bus.req_valid[r_owner] && !bus.w_full) begin
                    bus.w_en = 1'b1;
                    if (bus.req_last[r_owner]) begin
                        w_last_out      = 1'b1;
                        w_frame_cnt_nxt = r_frame_cnt + FRAME_CNT_W'(1);
                        w_rr_ptr_nxt    = w_owner_inc;
                        w_state_nxt     = IDLE;
                    end else if (r_beat_cnt == LAST_BEAT) begin
                        // Close the frame in the FIFO now; the tail is drained in DROP.
                        w_last_out      = 1'b1;
                        w_err_nxt       = 1'b1;
                        w_frame_cnt_nxt = r_frame_cnt + FRAME_CNT_W'(1);
                        w_rr_ptr_nxt    = w_owner_inc;
                        w_state_nxt     = DROP;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + BW'(1);
                    end
                end
            end
            DROP: begin
                bus.req_ready[r_owner] = 1'b1;
                if (bus.req_valid[r_owner] && bus.req_last[r_owner]) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.w_data   = {w_last_out, bus.req_data[r_owner]};
    assign owner        = r_owner;
    assign busy         = (r_state != IDLE);
    assign err_oversize = r_err;
    assign frame_cnt    = r_frame_cnt;
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Frame-atomic round-robin arbiter that shares the write port of one async FIFO between N_REQ ingress requesters in the wclk domain.
- Each granted frame is forwarded beat by beat until its last beat. Frames never interleave.
- w_full backpressure passes straight through to the owning requester.
- Oversize frames are truncated and their remainder is drained. The FIFO sees the frame end as the MSB of w_data.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 8, payload bits per beat. The FIFO is instantiated with DATA_WIDTH+1.
- MAX_BEATS, 1518, maximum beats per frame before forced truncation

Ports:
- wclk  in  1  write-domain clock
- wrst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester beat valid
- req_data  in  N_REQ*DATA_WIDTH  per-requester beat payload; requester i occupies slice i
- req_last  in  N_REQ  per-requester last beat of frame
- req_ready  out  N_REQ  per-requester beat accepted (combinational)
- w_en  out  1  FIFO write enable (combinational)
- w_data  out  DATA_WIDTH+1  {last, payload} to the FIFO
- w_full  in  1  FIFO full
- owner  out  $clog2(N_REQ)  current grant index (registered)
- busy  out  1  frame in progress (state != IDLE)
- err_oversize  out  1  one-cycle pulse on truncation
- frame_cnt  out  16  frames written to the FIFO, wraps at 2^16

Behaviour:
- Reset values: state=IDLE, owner=0, rr_ptr=0, beat_cnt=0, frame_cnt=0, err_oversize=0. req_ready, w_en and busy are all 0 while in reset.
- States: IDLE, XFER, DROP.
- IDLE:
  - If any req_valid is high, select the first requester at or after rr_ptr, wrapping modulo N_REQ.
  - Register owner, clear beat_cnt, go to XFER.
  - No beat moves in IDLE, so there is a 1-cycle arbitration bubble per frame.
- XFER:
  - req_ready[owner] = !w_full; all other ready bits are 0.
  - A beat transfers when req_valid[owner] && req_ready[owner]. On transfer: w_en=1 in the same cycle (zero latency) and w_data = {last_out, req_data[owner]}.
  - When w_full=1: w_en=0 and ready=0. Nothing is lost; the requester holds its beat.
  - On a transfer with req_last=1: last_out=1, frame_cnt+1, rr_ptr = owner+1 mod N_REQ, go to IDLE.
  - On a transfer with beat_cnt == MAX_BEATS-1 and req_last=0:
    - Force last_out=1, pulse err_oversize, frame_cnt+1.
    - rr_ptr = owner+1 mod N_REQ, go to DROP.
  - Otherwise: beat_cnt+1, remain in XFER.
- DROP:
  - req_ready[owner]=1 regardless of w_full; w_en=0.
  - Discard beats until a beat with req_last=1 is accepted, then go to IDLE.
- Valid and data from non-owners are ignored. Non-owners stay at ready=0 and may hold valid indefinitely.
- Fairness: after a frame completes, the just-served requester has the lowest priority. Each contending requester is served within N_REQ-1 frames.
- A single-beat frame (last on the first beat) is legal: XFER for one cycle, then IDLE.
- Dropping owner's valid mid-frame: the arbiter stays in XFER (no timeout). Ownership is held until last.
- Asynchronous reset mid-frame: w_en and ready drop immediately. The partial frame already in the FIFO is not repaired; the FIFO is reset alongside it by system reset.
- beat_cnt width is $clog2(MAX_BEATS+1). frame_cnt wraps silently.

Decomposition:
- Package fifo_arb_pkg: arb_state_t enum {IDLE, XFER, DROP} and the FRAME_CNT_W=16 constant.
- Sub-module rr_pick:
  - Combinational round-robin picker.
  - Inputs: req vector, rr_ptr. Outputs: grant index and any_req.
  - Parameterized by N_REQ.

Test Plan:
- Frame through: requester 1 sends 3 beats 0xA0,0xA1,0xA2, last on the third, w_full=0 -> after 1 bubble cycle, w_data sequence 0x0A0,0x0A1,0x1A2 on 3 consecutive cycles; frame_cnt=1; busy low afterwards.
- Fairness: all 4 requesters continuously send 2-beat frames -> grant order 0,1,2,3,0...; no interleaving; frame_cnt=8 after 8 frames; no requester is starved.
- Backpressure: hold w_full=1 for 5 cycles mid-frame -> req_ready[owner]=0 and w_en=0 for those 5 cycles; no beat lost or duplicated; FIFO contents match the sent order.
- Oversize: MAX_BEATS=4, requester 2 sends a 7-beat frame -> 4 beats written, the 4th with MSB=1; err_oversize pulses once; beats 5-7 are accepted with w_en=0; next grant goes to requester 3.
- Reset mid-frame: assert wrst_n low during beat 2 of a frame -> w_en=0 and req_ready=0 immediately; after release, state=IDLE, owner=0, frame_cnt=0; a new frame from requester 0 is granted normally.
- Back-to-back single-beat frames from requester 0 only -> one beat written every 2 cycles, each with MSB=1; frame_cnt increments per beat.
